rsc_alu_sequencer: RTL and testbench
====================================

Name: rsc_alu_sequencer

Overview:
Initiator side of the RSC datapath ALU interface: accepts one decoded ALU instruction, reads source operands from the register file, drives them onto the shared 16-bit bus with the ALU operand-load enables, fires the ALU output enable, and writes the captured result back.
Sits between instruction decode and the ALU/register file. Owns `aluInOut`, `opCode` and bus drive for ALU operations.

Parameters:
- DATA_W, 16, bus / register width.
- REG_AW, 4, register-file address width.
- IMM_SIGNED, 0, immediate extension for ADDI/SUBI: 0 = zero-extend, 1 = sign-extend the 4-bit immediate to DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  instruction valid; sampled only in IDLE.
- instr  in  16  [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt or imm.
- busy  out  1  high from the cycle after accept until return to IDLE.
- done  out  1  one-cycle pulse at completion (WB or ERR).
- illegal  out  1  one-cycle pulse with done for an unsupported op.
- opCode  out  4  ALU operation code.
- aluInOut  out  3  ALU enables {in1, in2, out}.
- bus_out  out  DATA_W  operand value driven to the bus.
- bus_oe  out  1  bus drive enable for bus_out.
- bus_in  in  DATA_W  bus value (ALU result during EXEC).
- rf_raddr  out  REG_AW  register-file read address.
- rf_rdata  in  DATA_W  register-file read data; combinational from rf_raddr.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- op_count  out  16  count of completed legal ops; wraps at 0xFFFF to 0.

Behaviour:
- Interface decisions:
  - One clock, `clk`.
  - Reset `rst` is asynchronous and active-high.
  - All outputs are registered or decoded from the registered state.
- Reset (also applies mid-operation):
  - State returns to IDLE immediately.
  - `busy`, `done`, `illegal`, `rf_we`, `bus_oe` = 0.
  - `aluInOut` = 000, `opCode` = 0000.
  - `bus_out`, `rf_*addr`, `rf_wdata`, `op_count` = 0.
  - No partial write-back is ever issued.
- Accept:
  - In IDLE with `start`=1, `instr` is latched on the clock edge and `start` is ignored while busy.
  - Op 0001–1001 is legal and goes to LD1.
  - Any other op goes to ERR.
- LD1 (1 cycle):
  - `rf_raddr`=rs, `bus_out`=rf_rdata, `bus_oe`=1, `aluInOut`=100.
  - Next state is LD2, except op 0111 (NOT), which goes to EXEC.
- LD2 (1 cycle):
  - `bus_oe`=1, `aluInOut`=010.
  - For op 1000/1001, `bus_out` is the extended imm; otherwise `rf_raddr`=rt and `bus_out`=rf_rdata.
- EXEC (1 cycle):
  - `bus_oe`=0, `aluInOut`=001.
  - `bus_in` is captured into the result register at the end of the cycle.
- WB (1 cycle):
  - `aluInOut`=000, `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=result.
  - `done`=1 and `op_count` increments.
  - Returns to IDLE.
- ERR (1 cycle):
  - `done`=1, `illegal`=1.
  - No bus drive, no write, `op_count` unchanged.
  - Returns to IDLE.
- `opCode` holds the latched op from LD1 through WB and is 0000 in IDLE/ERR.
- `aluInOut` is one-hot or 000, never multi-hot.
  - It is always 000 in IDLE/WB/ERR, so consecutive instructions re-trigger the ALU enables.
- `bus_oe`=1 only in LD1/LD2.
- Latency from accept edge to `done`:
  - 4 cycles for two-operand ops.
  - 3 cycles for NOT.
  - 1 cycle for illegal ops.
- Back-to-back: `start` held high is accepted again in the IDLE cycle after WB, giving throughput of one op per 5 cycles.
- rd == rs/rt is allowed; operands are read before write-back.

Test Plan:
- Reset mid-op: reset during LD2 of ADD → next sample shows IDLE, `aluInOut`=000, `bus_oe`=0, `rf_we` never asserted.
- ADD, R1=0x0005, R2=0x0003, instr=0x1312:
  - `aluInOut` sequence 100/010/001/000.
  - Bus carries 0x0005 then 0x0003.
  - ALU model returns 0x0008 → WB writes R3=0x0008, `done` 4 cycles after accept.
- NOT, R4=0x00FF, instr=0x7540:
  - LD2 is skipped.
  - Write R5=0xFF00, `done` 3 cycles after accept.
- SUBI, R6=0x0010, instr=0x9767:
  - LD2 bus value is 0x0007.
  - R7=0x0009.
  - With IMM_SIGNED=1 and imm=0xF, LD2 bus value is 0xFFFF.
- Illegal op instr=0xA123:
  - `done` and `illegal` pulse 1 cycle after accept.
  - No `bus_oe`, no `rf_we`, `op_count` unchanged.
- Back-to-back and wrap:
  - `start` held high for two ADDs → second accepted exactly one cycle after the first `done`.
  - Preload `op_count`=0xFFFF via 65535 ops (or force) → next legal op gives 0x0000.

Source files
------------

// File: rtl/rsc_alu_sequencer.sv
// Initiator side of the RSC ALU interface: fetches operands from the register file, sequences
// the ALU operand/output enables over the shared bus and writes the captured result back.
module rsc_alu_sequencer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_AW     = 4,
  parameter bit          IMM_SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       instr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        opCode,
  output logic [2:0]        aluInOut,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       op_count
);

  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpAddi = 4'h8;
  localparam logic [3:0] OpSubi = 4'h9;

  localparam logic [2:0] EnIn1 = 3'b100;
  localparam logic [2:0] EnIn2 = 3'b010;
  localparam logic [2:0] EnOut = 3'b001;

  typedef enum logic [2:0] {
    StIdle,
    StLd1,
    StLd2,
    StExec,
    StWb,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [15:0]         op_count_q, op_count_d;

  logic [3:0]          op_q;
  logic [3:0]          rd_q;
  logic [3:0]          rs_q;
  logic [3:0]          rt_q;
  logic                is_imm;
  logic [DATA_W-1:0]   imm_ext;

  assign op_q   = instr_q[15:12];
  assign rd_q   = instr_q[11:8];
  assign rs_q   = instr_q[7:4];
  assign rt_q   = instr_q[3:0];
  assign is_imm = (op_q == OpAddi) || (op_q == OpSubi);

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h9);
  endfunction

  // Size casts of a signed operand sign-extend, of an unsigned one zero-extend.
  always_comb begin
    if (IMM_SIGNED) begin
      imm_ext = DATA_W'($signed(rt_q));
    end else begin
      imm_ext = DATA_W'(rt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      result_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      result_q   <= result_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    result_d   = result_q;
    op_count_d = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          instr_d = instr;
          state_d = op_legal(instr[15:12]) ? StLd1 : StErr;
        end
      end
      StLd1: begin
        // NOT is unary, so the second operand load is skipped.
        state_d = (op_q == OpNot) ? StExec : StLd2;
      end
      StLd2: begin
        state_d = StExec;
      end
      StExec: begin
        result_d = bus_in;
        state_d  = StWb;
      end
      StWb: begin
        op_count_d = op_count_q + 16'd1;
        state_d    = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    opCode   = 4'h0;
    aluInOut = 3'b000;
    bus_out  = '0;
    bus_oe   = 1'b0;
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (state_q)
      StIdle: begin
      end
      StLd1: begin
        busy     = 1'b1;
        opCode   = op_q;
        aluInOut = EnIn1;
        rf_raddr = REG_AW'(rs_q);
        bus_out  = rf_rdata;
        bus_oe   = 1'b1;
      end
      StLd2: begin
        busy     = 1'b1;
        opCode   = op_q;
        aluInOut = EnIn2;
        bus_oe   = 1'b1;
        if (is_imm) begin
          bus_out = imm_ext;
        end else begin
          rf_raddr = REG_AW'(rt_q);
          bus_out  = rf_rdata;
        end
      end
      StExec: begin
        busy     = 1'b1;
        opCode   = op_q;
        aluInOut = EnOut;
      end
      StWb: begin
        busy     = 1'b1;
        done     = 1'b1;
        opCode   = op_q;
        rf_we    = 1'b1;
        rf_waddr = REG_AW'(rd_q);
        rf_wdata = result_q;
      end
      StErr: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign op_count = op_count_q;

endmodule

// File: tb/tb_rsc_alu_sequencer.sv
// Bench for rsc_alu_sequencer: register file and ALU environment, a per-cycle expected-output
// schedule built from the instruction semantics, and directed instruction vectors.
module tb_rsc_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr;

  logic        busy, done, illegal, bus_oe, rf_we;
  logic [3:0]  opCode, rf_raddr, rf_waddr;
  logic [2:0]  aluInOut;
  logic [15:0] bus_out, bus_in, rf_rdata, rf_wdata, op_count;

  logic        s_busy, s_done, s_illegal, s_bus_oe, s_rf_we;
  logic [3:0]  s_opCode, s_rf_raddr, s_rf_waddr;
  logic [2:0]  s_aluInOut;
  logic [15:0] s_bus_out, s_rf_rdata, s_rf_wdata, s_op_count;
  logic        unused_s;

  always #5 clk = ~clk;

  rsc_alu_sequencer u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .instr    (instr),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .opCode   (opCode),
    .aluInOut (aluInOut),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .bus_in   (bus_in),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .op_count (op_count)
  );

  // Sign-extending variant, run in lockstep; only its LD2 bus value is of interest.
  rsc_alu_sequencer #(.IMM_SIGNED(1'b1)) u_dut_s (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .instr    (instr),
    .busy     (s_busy),
    .done     (s_done),
    .illegal  (s_illegal),
    .opCode   (s_opCode),
    .aluInOut (s_aluInOut),
    .bus_out  (s_bus_out),
    .bus_oe   (s_bus_oe),
    .bus_in   (16'h0000),
    .rf_raddr (s_rf_raddr),
    .rf_rdata (s_rf_rdata),
    .rf_we    (s_rf_we),
    .rf_waddr (s_rf_waddr),
    .rf_wdata (s_rf_wdata),
    .op_count (s_op_count)
  );

  assign unused_s = ^{s_busy, s_done, s_illegal, s_bus_oe, s_rf_we, s_opCode, s_rf_waddr,
                      s_rf_wdata, s_op_count};

  // ---------------- environment: register file and ALU ----------------
  logic [15:0] regs [16];
  logic [15:0] alu_a, alu_b;
  int          wr_count = 0;

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      4'h1, 4'h8: return a + b;
      4'h2, 4'h9: return a - b;
      4'h3:       return a & b;
      4'h4:       return a | b;
      4'h5:       return a ^ b;
      4'h6:       return a << b[3:0];
      4'h7:       return ~a;
      default:    return 16'h0000;
    endcase
  endfunction

  assign rf_rdata   = regs[rf_raddr];
  assign s_rf_rdata = regs[s_rf_raddr];
  assign bus_in     = aluInOut[0] ? alu_fn(opCode, alu_a, alu_b) : 16'h0000;

  always @(posedge clk) begin
    if (aluInOut[2]) alu_a <= bus_out;
    if (aluInOut[1]) alu_b <= bus_out;
    if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
      wr_count       <= wr_count + 1;
    end
  end

  // ---------------- model: expected per-cycle outputs ----------------
  typedef struct {
    logic        busy, done, ill, oe, we;
    logic [3:0]  opc, waddr;
    logic [2:0]  alu;
    logic [15:0] bus, wdata;
  } exp_t;

  exp_t        expq [$];
  logic [15:0] mregs [16];
  logic [15:0] mcnt;
  bit          chk = 1'b0;
  bit          s_watch = 1'b0;
  int          s_seen = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic exp_t idle_rec();
    exp_t e;
    e = '{busy: 1'b0, done: 1'b0, ill: 1'b0, oe: 1'b0, we: 1'b0,
          opc: 4'h0, waddr: 4'h0, alu: 3'b000, bus: 16'h0, wdata: 16'h0};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Builds the cycle schedule of one instruction, starting with its accept (IDLE) cycle.
  task automatic push_op(input logic [15:0] ins, output int n);
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] a, b;
    exp_t        e;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    expq.push_back(idle_rec());
    if (op == 4'h0 || op > 4'h9) begin
      e = idle_rec(); e.busy = 1'b1; e.done = 1'b1; e.ill = 1'b1;
      expq.push_back(e);
      n = 1;
      return;
    end
    a = mregs[rs];
    b = (op >= 4'h8) ? {12'h000, rt} : mregs[rt];
    e = idle_rec(); e.busy = 1'b1; e.opc = op; e.alu = 3'b100; e.oe = 1'b1; e.bus = a;
    expq.push_back(e);
    n = 3;
    if (op != 4'h7) begin
      e.alu = 3'b010; e.bus = b;
      expq.push_back(e);
      n = 4;
    end
    e = idle_rec(); e.busy = 1'b1; e.opc = op; e.alu = 3'b001;
    expq.push_back(e);
    e.alu = 3'b000; e.done = 1'b1; e.we = 1'b1; e.waddr = rd; e.wdata = alu_fn(op, a, b);
    expq.push_back(e);
    mregs[rd] = e.wdata;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk && !rst) begin
      e = (expq.size() > 0) ? expq.pop_front() : idle_rec();
      check("busy",     busy,     e.busy);
      check("done",     done,     e.done);
      check("illegal",  illegal,  e.ill);
      check("opCode",   opCode,   e.opc);
      check("aluInOut", aluInOut, e.alu);
      check("bus_oe",   bus_oe,   e.oe);
      check("rf_we",    rf_we,    e.we);
      check("op_count", op_count, mcnt);
      if (e.oe) check("bus_out", bus_out, e.bus);
      if (e.we) begin
        check("rf_waddr", rf_waddr, e.waddr);
        check("rf_wdata", rf_wdata, e.wdata);
      end
      if (e.done && !e.ill) mcnt = mcnt + 16'd1;
      if (s_watch && s_aluInOut == 3'b010) begin
        check("signed_imm_bus", s_bus_out, 16'hFFFF);
        s_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int idx, input logic [15:0] val);
    regs[idx]  <= val;
    mregs[idx] = val;
  endtask

  // Starts in the IDLE cycle just after a rising edge; returns in the next IDLE cycle.
  task automatic issue(input logic [15:0] ins, input bit hold);
    int n;
    push_op(ins, n);
    start = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int wc;
    rst   = 1'b1;
    start = 1'b0;
    instr = 16'h0000;
    mcnt  = 16'h0000;
    for (int i = 0; i < 16; i++) preload(i, 16'h0000);
    #2;
    check("reset_busy",     busy,     1'b0);
    check("reset_alu",      aluInOut, 3'b000);
    check("reset_bus_oe",   bus_oe,   1'b0);
    check("reset_op_count", op_count, 16'h0000);
    preload(1, 16'h0005);
    preload(2, 16'h0003);
    preload(4, 16'h00FF);
    preload(6, 16'h0010);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk = 1'b1;

    issue(16'h1312, 1'b0);
    check("add_r3", regs[3], 16'h0008);
    check("add_count", op_count, 16'h0001);

    issue(16'h7540, 1'b0);
    check("not_r5", regs[5], 16'hFF00);

    issue(16'h9767, 1'b0);
    check("subi_r7", regs[7], 16'h0009);

    s_watch = 1'b1;
    issue(16'h976F, 1'b0);
    s_watch = 1'b0;
    check("subi_f_r7", regs[7], 16'h0001);
    check("signed_imm_seen", s_seen, 1);

    wc = wr_count;
    issue(16'hA123, 1'b0);
    issue(16'h0456, 1'b0);
    check("illegal_no_write", wr_count, wc);
    check("illegal_count", op_count, 16'h0004);

    issue(16'h1312, 1'b1);
    issue(16'h2A12, 1'b0);
    check("b2b_r10", regs[10], 16'h0002);

    issue(16'h1111, 1'b0);
    check("rd_eq_rs_r1", regs[1], 16'h000A);

    // Abort an ADD in its LD2 cycle.
    chk   = 1'b0;
    wc    = wr_count;
    start = 1'b1;
    instr = 16'h1312;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_ld1_alu", aluInOut, 3'b100);
    @(posedge clk); #1;
    check("abort_ld2_alu", aluInOut, 3'b010);
    rst = 1'b1;
    #1;
    check("abort_busy",   busy,     1'b0);
    check("abort_alu",    aluInOut, 3'b000);
    check("abort_bus_oe", bus_oe,   1'b0);
    check("abort_done",   done,     1'b0);
    @(posedge clk); #1;
    check("abort_rf_we", rf_we, 1'b0);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_no_write", wr_count, wc);
    check("abort_count", op_count, 16'h0000);
    mcnt = 16'h0000;
    chk  = 1'b1;

    force u_dut.op_count_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    @(posedge clk); #1;
    release u_dut.op_count_q;
    issue(16'h8C1F, 1'b0);
    check("wrap_count", op_count, 16'h0000);
    check("addi_r12", regs[12], 16'h0019);

    repeat (2) begin
      @(posedge clk); #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
